// File: rtl/qspi_rx_packer_fifo.sv
// Receive-side packer and show-ahead FIFO between the QSPI shift engine and the DMA engine.
// Bytes are packed little-endian into words; a partial word is zero-padded and pushed on the last byte.
module qspi_rx_packer_fifo #(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     byte_valid_i,
   input  logic [7:0]               byte_data_i,
   input  logic                     byte_last_i,
   output logic                     byte_ready_o,
   input  logic                     flush_i,
   output logic [DATA_WIDTH-1:0]    rx_data_dma,
   output logic                     rx_empty,
   input  logic                     rx_ren,
   output logic [$clog2(DEPTH):0]   rx_level_o,
   output logic                     rx_afull_o,
   output logic                     underflow_o,
   input  logic                     clr_err_i
);

   localparam int BPW = DATA_WIDTH / 8;
   localparam int AW  = $clog2(DEPTH);
   localparam int LW  = AW + 1;
   localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(BPW - 1);
   localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_THRESH);

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] asm_q, asm_d, word;
   logic [LW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
   logic                  afull_q, uf_q, uf_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  empty, full, accept, push, pop;

   // The extra pointer MSB separates a full FIFO from an empty one.
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   assign byte_ready_o = rst_n && !full;
   assign accept       = byte_valid_i && byte_ready_o && !flush_i;
   assign push         = accept && (byte_last_i || (cnt_q == LAST_IDX));
   assign pop          = rx_ren && !empty && !flush_i;

   // Unfilled byte lanes stay zero because the assembly register clears after every push.
   always_comb begin
      word = asm_q;
      for (int k = 0; k < BPW; k++) begin
         if (cnt_q == CW'(k)) word[8*k +: 8] = byte_data_i;
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      uf_d    = uf_q;
      if (clr_err_i)          uf_d = 1'b0;
      if (rx_ren && empty)    uf_d = 1'b1;
      if (flush_i) begin
         cnt_d   = '0;
         asm_d   = '0;
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
      end else begin
         if (accept) begin
            if (push) begin
               cnt_d = '0;
               asm_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
               asm_d = word;
            end
         end
         if (push) wptr_d = wptr_q + 1'b1;
         if (pop)  rptr_d = rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         asm_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         afull_q <= 1'b0;
         uf_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         afull_q <= (level_d >= AFULL_L);
         uf_q    <= uf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= word;
   end

   assign rx_data_dma = empty ? '0 : mem_q[rptr_q[AW-1:0]];
   assign rx_empty    = empty;
   assign rx_level_o  = level_q;
   assign rx_afull_o  = afull_q;
   assign underflow_o = uf_q;

endmodule

// File: tb/tb_qspi_rx_packer_fifo.sv
// Bench for qspi_rx_packer_fifo: queue-based reference model, directed scenarios and randomized traffic.
module tb_qspi_rx_packer_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AFULL = 12;
   localparam int BPW   = DW / 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          byte_valid = 1'b0;
   logic [7:0]    byte_data = 8'h00;
   logic          byte_last = 1'b0;
   logic          byte_ready;
   logic          flush = 1'b0;
   logic [DW-1:0] rx_data;
   logic          rx_empty;
   logic          rx_ren = 1'b0;
   logic [LW-1:0] rx_level;
   logic          rx_afull;
   logic          underflow;
   logic          clr_err = 1'b0;

   int            total = 0;
   int            bad = 0;
   logic          mon_en = 1'b0;
   logic          rnd_done = 1'b0;

   logic [DW-1:0] exp_q[$];
   logic [7:0]    part[$];
   logic          m_uf = 1'b0;

   qspi_rx_packer_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
      .clk(clk), .rst_n(rst_n),
      .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_last_i(byte_last),
      .byte_ready_o(byte_ready), .flush_i(flush),
      .rx_data_dma(rx_data), .rx_empty(rx_empty), .rx_ren(rx_ren),
      .rx_level_o(rx_level), .rx_afull_o(rx_afull), .underflow_o(underflow),
      .clr_err_i(clr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      part.delete();
   endtask

   task automatic model_accept(input logic [7:0] b, input logic last);
      logic [DW-1:0] w;
      part.push_back(b);
      if (part.size() == BPW || last) begin
         w = '0;
         foreach (part[i]) w = w | (DW'(part[i]) << (8 * i));
         exp_q.push_back(w);
         part.delete();
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      int n;
      n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      byte_last  = last;
      forever begin
         @(negedge clk);
         if (byte_ready) break;
         n++;
         if (n > 300) begin
            chk("send_timeout", 64'(n), 64'd0);
            byte_valid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      model_accept(b, last);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         rx_ren = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      rx_ren = 1'b0;
      if (n >= 200) chk("drain_timeout", 64'(n), 64'd0);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Monitor: compares every visible output against the model, then retires pops.
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         chk("level", 64'(rx_level), 64'(exp_q.size()));
         chk("empty", 64'(rx_empty), 64'(exp_q.size() == 0));
         chk("ready", 64'(byte_ready), 64'(exp_q.size() < DEPTH));
         chk("afull", 64'(rx_afull), 64'(exp_q.size() >= AFULL));
         chk("underflow", 64'(underflow), 64'(m_uf));
         if (exp_q.size() > 0) chk("head", 64'(rx_data), 64'(exp_q[0]));
         else                  chk("head_empty", 64'(rx_data), 64'd0);
         if (rx_ren && exp_q.size() == 0) m_uf = 1'b1;
         else if (clr_err)                m_uf = 1'b0;
         if (rx_ren && !flush && exp_q.size() > 0) void'(exp_q.pop_front());
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(byte_ready), 64'd0);
      chk("rst_empty", 64'(rx_empty), 64'd1);
      chk("rst_level", 64'(rx_level), 64'd0);
      chk("rst_afull", 64'(rx_afull), 64'd0);
      chk("rst_uf", 64'(underflow), 64'd0);
      chk("rst_data", 64'(rx_data), 64'd0);
      @(posedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Eight bytes, DMA idle
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
      @(negedge clk);
      chk("t1_level", 64'(rx_level), 64'd2);
      chk("t1_head", 64'(rx_data), 64'h04030201);
      step();
      drain();

      // Five bytes with last on the fifth
      for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i), i == 4);
      @(negedge clk);
      chk("t2_head0", 64'(rx_data), 64'h14131211);
      step();
      rx_ren = 1'b1; step(); rx_ren = 1'b0;
      @(negedge clk);
      chk("t2_head1", 64'(rx_data), 64'h00000015);
      step();
      drain();

      // Fill to DEPTH, then one pop frees space for a waiting byte
      for (int i = 0; i < DEPTH * BPW; i++) send_byte(8'($urandom), 1'b0);
      @(negedge clk);
      chk("t3_ready_full", 64'(byte_ready), 64'd0);
      chk("t3_afull", 64'(rx_afull), 64'd1);
      chk("t3_level", 64'(rx_level), 64'(DEPTH));
      step();
      fork
         send_byte(8'h5A, 1'b1);
         begin
            repeat (2) step();
            rx_ren = 1'b1; step(); rx_ren = 1'b0;
         end
      join
      drain();

      // Simultaneous push and pop at level 1 and at DEPTH-1
      for (int lv = 0; lv < 2; lv++) begin
         int words;
         words = (lv == 0) ? 1 : DEPTH - 1;
         for (int i = 0; i < words * BPW; i++) send_byte(8'($urandom), 1'b0);
         for (int i = 0; i < BPW - 1; i++) send_byte(8'($urandom), 1'b0);
         rx_ren = 1'b1;
         send_byte(8'($urandom), 1'b0);
         rx_ren = 1'b0;
         @(negedge clk);
         chk("t4_level", 64'(rx_level), 64'(words));
         step();
         drain();
      end

      // Underflow, set-wins-over-clear, then clear
      rx_ren = 1'b1; step(); rx_ren = 1'b0;
      @(negedge clk);
      chk("t5_uf_set", 64'(underflow), 64'd1);
      chk("t5_level", 64'(rx_level), 64'd0);
      step();
      rx_ren = 1'b1; clr_err = 1'b1; step(); rx_ren = 1'b0;
      @(negedge clk);
      chk("t5_uf_setwins", 64'(underflow), 64'd1);
      step(); clr_err = 1'b0;
      @(negedge clk);
      chk("t5_uf_clr", 64'(underflow), 64'd0);
      step();

      // Two words plus two bytes, then flush
      for (int i = 0; i < 2 * BPW + 2; i++) send_byte(8'($urandom), 1'b0);
      flush = 1'b1; step(); flush = 1'b0;
      model_clear();
      @(negedge clk);
      chk("t6_empty", 64'(rx_empty), 64'd1);
      chk("t6_level", 64'(rx_level), 64'd0);
      step();
      for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 1'b0);
      @(negedge clk);
      chk("t6_head", 64'(rx_data), 64'hA3A2A1A0);
      step();
      drain();

      // Reset mid-transfer with words stored and a partial word pending
      for (int i = 0; i < BPW + 2; i++) send_byte(8'($urandom), 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t7_ready_rst", 64'(byte_ready), 64'd0);
      step();
      rst_n = 1'b1;
      model_clear();
      m_uf = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), 1'b0);
      @(negedge clk);
      chk("t7_head", 64'(rx_data), 64'hC3C2C1C0);
      step();
      drain();

      // Randomized traffic with concurrent DMA pops
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               if ($urandom_range(0, 3) == 0) step();
               send_byte(8'($urandom), $urandom_range(0, 7) == 0);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               step();
               rx_ren = !rx_empty && ($urandom_range(0, 2) != 0);
            end
            rx_ren = 1'b0;
         end
      join
      if (part.size() > 0) send_byte(8'h77, 1'b1);
      step();
      drain();
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
